// File: rtl/truth_table_sweeper_if.sv
// truth_table_sweeper_if: sweep handshake, expected mask, function-block pins and results
interface truth_table_sweeper_if;
  logic        start;
  logic [15:0] expected;
  logic        s;
  logic        a;
  logic        b;
  logic        c;
  logic        d;
  logic        busy;
  logic        done;
  logic [15:0] table_out;
  logic [4:0]  mismatch_cnt;
  logic [3:0]  first_bad;
  logic        pass;
  modport master (
    output start, expected, s,
    input  a, b, c, d, busy, done, table_out, mismatch_cnt, first_bad, pass
  );
  modport slave (
    input  start, expected, s,
    output a, b, c, d, busy, done, table_out, mismatch_cnt, first_bad, pass
  );
endinterface

// File: rtl/truth_table_sweeper.sv
// truth_table_sweeper: drives all 16 {a,b,c,d} vectors, samples s after SETTLE cycles and scores it against a mask
module truth_table_sweeper #(
  parameter int SETTLE = 1
) (
  input logic                 clk,
  input logic                 rst_n,
  truth_table_sweeper_if.slave bus
);
  typedef enum logic [1:0] {IDLE, DRIVE, SAMPLE, DONE} state_t;
  state_t      state;
  logic [3:0]  idx;
  logic [3:0]  cnt;
  logic [15:0] exp_q;
  logic [15:0] table_q;
  logic [4:0]  miss_q;
  logic [3:0]  first_q;
  logic        pass_q;
  logic        busy_q;
  logic        done_q;
  logic        miss;
  assign miss = bus.s ^ exp_q[idx];
  assign {bus.a, bus.b, bus.c, bus.d} = idx;
  assign bus.busy         = busy_q;
  assign bus.done         = done_q;
  assign bus.table_out    = table_q;
  assign bus.mismatch_cnt = miss_q;
  assign bus.first_bad    = first_q;
  assign bus.pass         = pass_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      idx     <= '0;
      cnt     <= '0;
      exp_q   <= '0;
      table_q <= '0;
      miss_q  <= '0;
      first_q <= '0;
      pass_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      case (state)
        IDLE: if (bus.start) begin
          exp_q   <= bus.expected;
          table_q <= '0;
          miss_q  <= '0;
          first_q <= '0;
          pass_q  <= 1'b0;
          idx     <= '0;
          cnt     <= '0;
          busy_q  <= 1'b1;
          state   <= DRIVE;
        end
        DRIVE: begin
          cnt   <= (cnt == 4'(SETTLE - 1)) ? 4'd0 : cnt + 4'd1;
          state <= (cnt == 4'(SETTLE - 1)) ? SAMPLE : DRIVE;
        end
        SAMPLE: begin
          table_q[idx] <= bus.s;
          miss_q       <= miss_q + 5'(miss);
          if (miss && miss_q == 5'd0) first_q <= idx;
          if (idx == 4'd15) begin
            pass_q <= (miss_q == 5'd0) && !miss;
            busy_q <= 1'b0;
            done_q <= 1'b1;
            state  <= DONE;
          end else begin
            idx   <= idx + 4'd1;
            state <= DRIVE;
          end
        end
        default: begin
          done_q <= 1'b0;
          state  <= IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_truth_table_sweeper.sv
// tb_truth_table_sweeper: table-driven sweeps on SETTLE=1 and SETTLE=3 instances plus handshake/reset sequences
module tb_truth_table_sweeper;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        use3 = 1'b0;
  logic        xor_fn = 1'b0;
  logic [15:0] expected = '0;
  int          checks = 0;
  int          failures = 0;
  int          held[16];
  always #5 clk = ~clk;
  truth_table_sweeper_if bus1 ();
  truth_table_sweeper_if bus3 ();
  assign bus1.start    = start & ~use3;
  assign bus3.start    = start & use3;
  assign bus1.expected = expected;
  assign bus3.expected = expected;
  assign bus1.s = xor_fn & (bus1.a ^ bus1.b ^ bus1.c ^ bus1.d);
  assign bus3.s = xor_fn & (bus3.a ^ bus3.b ^ bus3.c ^ bus3.d);
  truth_table_sweeper #(.SETTLE(1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1.slave));
  truth_table_sweeper #(.SETTLE(3)) dut3 (.clk(clk), .rst_n(rst_n), .bus(bus3.slave));
  logic [3:0]  idx_m;
  logic        busy_m, done_m, pass_m;
  logic [15:0] table_m;
  logic [4:0]  cnt_m;
  logic [3:0]  fb_m;
  assign idx_m   = use3 ? {bus3.a, bus3.b, bus3.c, bus3.d} : {bus1.a, bus1.b, bus1.c, bus1.d};
  assign busy_m  = use3 ? bus3.busy : bus1.busy;
  assign done_m  = use3 ? bus3.done : bus1.done;
  assign pass_m  = use3 ? bus3.pass : bus1.pass;
  assign table_m = use3 ? bus3.table_out : bus1.table_out;
  assign cnt_m   = use3 ? bus3.mismatch_cnt : bus1.mismatch_cnt;
  assign fb_m    = use3 ? bus3.first_bad : bus1.first_bad;
  typedef struct {
    logic        fn;
    logic [15:0] mask;
    logic [15:0] tbl;
    logic [4:0]  cnt;
    logic [3:0]  fb;
    logic        pass;
  } vec_t;
  vec_t vecs[8];
  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, got, want);
    end
  endtask
  // Counts busy cycles and per-vector hold cycles until done, bounded.
  task automatic watch(input int mid_at, input logic [15:0] mid_exp, output int nbusy, output bit seen);
    nbusy = 0;
    seen = 0;
    for (int k = 0; k < 16; k++) held[k] = 0;
    for (int i = 0; i < 400 && !seen; i++) begin
      @(negedge clk);
      if (i == mid_at) expected = mid_exp;
      if (busy_m) begin
        nbusy++;
        held[idx_m]++;
      end
      if (done_m) seen = 1;
    end
  endtask
  task automatic check_result(input string tag, input int nbusy, input bit seen, input int settle,
                              input logic [15:0] tbl, input logic [4:0] cnt, input logic [3:0] fb,
                              input logic ps);
    int bad_hold;
    bad_hold = 0;
    for (int k = 0; k < 16; k++) if (held[k] != settle + 1) bad_hold++;
    check({tag, " done_seen"}, 32'(seen), 32'd1);
    check({tag, " busy_cycles"}, nbusy, 16 * (settle + 1));
    check({tag, " hold_bad_vectors"}, bad_hold, 0);
    check({tag, " table_out"}, table_m, tbl);
    check({tag, " mismatch_cnt"}, cnt_m, cnt);
    check({tag, " first_bad"}, fb_m, fb);
    check({tag, " pass"}, pass_m, ps);
    @(negedge clk);
    check({tag, " done_one_cycle"}, done_m, 1'b0);
  endtask
  initial begin
    int  nb;
    bit  seen;
    vecs[0] = '{1'b0, 16'h0000, 16'h0000, 5'd0,  4'd0,  1'b1};
    vecs[1] = '{1'b1, 16'h6996, 16'h6996, 5'd0,  4'd0,  1'b1};
    vecs[2] = '{1'b1, 16'h0000, 16'h6996, 5'd8,  4'd1,  1'b0};
    vecs[3] = '{1'b0, 16'hFFFF, 16'h0000, 5'd16, 4'd0,  1'b0};
    vecs[4] = '{1'b0, 16'h0001, 16'h0000, 5'd1,  4'd0,  1'b0};
    vecs[5] = '{1'b1, 16'h6997, 16'h6996, 5'd1,  4'd0,  1'b0};
    vecs[6] = '{1'b0, 16'h8000, 16'h0000, 5'd1,  4'd15, 1'b0};
    vecs[7] = '{1'b1, 16'hE996, 16'h6996, 5'd1,  4'd15, 1'b0};
    #12 rst_n = 1'b1;
    @(negedge clk);
    check("reset idx", idx_m, 4'd0);
    check("reset busy", busy_m, 1'b0);
    for (int v = 0; v < 8; v++) begin
      use3 = 1'b0;
      xor_fn = vecs[v].fn;
      expected = vecs[v].mask;
      @(negedge clk);
      start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      watch(-1, 16'h0, nb, seen);
      check_result($sformatf("vec%0d", v), nb, seen, 1, vecs[v].tbl, vecs[v].cnt, vecs[v].fb, vecs[v].pass);
    end
    // Asynchronous reset mid-cycle while prior results are non-zero.
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("async idx", idx_m, 4'd0);
    check("async table", table_m, 16'h0);
    check("async cnt", cnt_m, 5'd0);
    check("async first_bad", fb_m, 4'd0);
    check("async pass", pass_m, 1'b0);
    check("async busy", busy_m, 1'b0);
    check("async done", done_m, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    // Back-to-back sweeps with start held; expected changes mid-sweep.
    xor_fn = 1'b1;
    expected = 16'h6996;
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1;
    watch(5, 16'h0000, nb, seen);
    check("b2b1 done_seen", 32'(seen), 32'd1);
    check("b2b1 table", table_m, 16'h6996);
    check("b2b1 pass", pass_m, 1'b1);
    @(negedge clk);
    check("b2b idle busy", busy_m, 1'b0);
    check("b2b idle done", done_m, 1'b0);
    @(negedge clk);
    check("b2b restart busy", busy_m, 1'b1);
    watch(5, 16'h6996, nb, seen);
    start = 1'b0;
    check("b2b2 done_seen", 32'(seen), 32'd1);
    check("b2b2 busy_cycles", nb, 31);
    check("b2b2 cnt", cnt_m, 5'd8);
    check("b2b2 first_bad", fb_m, 4'd1);
    check("b2b2 pass", pass_m, 1'b0);
    repeat (3) @(negedge clk);
    check("b2b no restart", busy_m, 1'b0);
    // Reset while idx=7 aborts the sweep with no done pulse.
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    seen = 0;
    for (int i = 0; i < 100 && !seen; i++) begin
      @(negedge clk);
      if (idx_m == 4'd7) seen = 1;
    end
    check("abort reached idx7", 32'(seen), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("abort idx", idx_m, 4'd0);
    check("abort busy", busy_m, 1'b0);
    check("abort table", table_m, 16'h0);
    @(negedge clk);
    rst_n = 1'b1;
    watch(-1, 16'h0, nb, seen);
    check("abort no done", 32'(seen), 32'd0);
    check("abort no busy", nb, 0);
    // SETTLE=3 instance.
    use3 = 1'b1;
    for (int r = 0; r < 2; r++) begin
      expected = r == 0 ? 16'h6996 : 16'h8001;
      @(negedge clk);
      start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      watch(-1, 16'h0, nb, seen);
      if (r == 0) check_result("s3 match", nb, seen, 3, 16'h6996, 5'd0, 4'd0, 1'b1);
      else check_result("s3 miss", nb, seen, 3, 16'h6996, 5'd10, 4'd0, 1'b0);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
